memtest_sequencer: RTL and testbench
====================================

# memtest_sequencer

AXI-Lite master that autonomously brings up and runs the LPDDR4 memory test by sequencing writes and reads to the memory-test control register block (REG0–REG9 address map). On `start` it releases PHY/controller/AXI resets, loads pattern/size configuration, and pulses memtest start. It then polls for completion with a bounded timeout and latches the pass/fail and DQ-fail results. It sits between a host/boot FSM and the register slave, replacing manual software register pokes.

## Interface
- `ADDR_WIDTH`, 32, AXI address width.
- `DATA_WIDTH`, 32, AXI data width (fixed 32 for this block).
- `POLL_GAP`, 16, idle cycles between REG1 status polls (≥1).
- `MAX_POLLS`, 65535, poll reads before declaring timeout (≤ 2^16−1).

- `axi_aclk`  in  1  sole clock.
- `axi_reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin sequence; sampled only in IDLE or DONE.
- `cfg_pattern`  in  64  memtest data pattern → REG4 (low), REG5 (high).
- `cfg_lfsr_en`  in  1  → REG6 bit0.
- `cfg_size`  in  32  → REG9.
- `busy`  out  1  sequence in progress.
- `done`  out  1  level; sequence finished, held until next accepted `start`.
- `pass`  out  1  `done` & !`fail` & !`timeout`.
- `fail`  out  1  latched REG1 bit1.
- `timeout`  out  1  poll limit reached.
- `dq_fail_q`  out  32  latched REG0 value.
- `poll_count`  out  16  REG1 reads issued in current run.
- AXI master: `axi_awaddr` out ADDR_WIDTH, `axi_awvalid` out 1, `axi_awready` in 1, `axi_wdata` out 32, `axi_wstrb` out 4, `axi_wvalid` out 1, `axi_wlast` out 1, `axi_wready` in 1, `axi_bvalid` in 1, `axi_bready` out 1, `axi_araddr` out ADDR_WIDTH, `axi_arvalid` out 1, `axi_arready` in 1, `axi_rdata` in 32, `axi_rvalid` in 1, `axi_rlast` in 1, `axi_rready` out 1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, GAP, DONE. A 4-bit step index selects the register and data.
- Steps: 0 W REG3=0x1F; 1 W REG4=pattern[31:0]; 2 W REG5=pattern[63:32]; 3 W REG6={31'b0,lfsr}; 4 W REG9=size; 5 W REG2=0x2; 6 W REG2=0x3; 7 R REG1 (poll); 8 R REG0; 9 W REG2=0x2 (clear start).
- Address = register index × 4. `axi_wstrb`=4'hF. `axi_wlast`=`axi_wvalid`.
- IDLE/DONE + `start`: clear `fail`/`timeout`/`dq_fail_q`/`poll_count`/`done`, set step 0, go to WR_REQ.
- WR_REQ: assert `axi_awvalid` and `axi_wvalid` in the same cycle. Each is held until its own ready is seen, then dropped independently. When both channels have handshaken, go to WR_RESP.
- WR_RESP: `axi_bready`=1. On `axi_bvalid`, advance step. Next step is a write → WR_REQ, a read → RD_REQ, past step 9 → DONE. `bresp` is ignored.
- RD_REQ: hold `axi_arvalid` until `axi_arready`, then go to RD_DATA.
- RD_DATA: `axi_rready`=1. On `axi_rvalid`:
  - step 7: `poll_count`+1 (saturating).
    - If rdata[0]=1: latch `fail`=rdata[1], go to step 8.
    - Else if `poll_count`+1 = `MAX_POLLS`: set `timeout`, skip to step 9.
    - Else go to GAP.
  - step 8: latch `dq_fail_q`=rdata, go to step 9.
- GAP: count `POLL_GAP` cycles, then go to RD_REQ (step 7).
- DONE: `done`=1, `busy`=0. Results are held.
- `start` while `busy` is ignored. Config inputs are sampled at the step that uses them.

## Timing
- Reset (async, immediate): state IDLE; all AXI valid/ready outputs 0; addresses/data 0; `busy`/`done`/`pass`/`fail`/`timeout` 0; `dq_fail_q`=0; `poll_count`=0.
- Reset mid-transaction abandons it with no completion. Valids drop in the same cycle reset asserts.
- All outputs are registered. `busy` rises the cycle after `start` is accepted.
- Zero-wait slave (ready always high, 1-cycle response): write = WR_REQ 1 cycle + WR_RESP until `bvalid`. Read = 1 cycle AR + RD_DATA until `rvalid`.
- Handshakes complete where valid & ready are high at a rising edge. No combinational path exists from ready to valid.
- `awready` and `wready` arriving in different cycles is legal. `bvalid` arriving before both handshakes complete is not expected and is not handled.

## Test plan
- Zero-wait slave model, done returns on 3rd poll, fail=0, REG0=0xDEADBEEF → write order REG3,4,5,6,9,2,2,(REG1×3),REG0,REG2 with correct data; `pass`=1, `poll_count`=3, `dq_fail_q`=0xDEADBEEF.
- REG1 returns 0x3 on first poll → `fail`=1, `pass`=0, `done`=1, final write REG2=0x2.
- Done never set, `MAX_POLLS`=4 → exactly 4 REG1 reads spaced ≥`POLL_GAP` cycles, then REG2=0x2 write; `timeout`=1, REG0 not read.
- Slave delays `wready` 3 cycles after `awready` and `bvalid` 5 cycles → `awvalid` drops after 1 cycle, `wvalid` held 4 cycles, no extra writes.
- `axi_reset` pulsed during step 3 WR_RESP → all outputs zero immediately. A subsequent `start` reruns from step 0. `start` pulsed during `busy` has no effect.

Source files
------------

// File: rtl/memtest_sequencer.sv
// memtest_sequencer: AXI-Lite master that walks the memory-test register
// block through bring-up (resets, pattern, size, start pulse), polls REG1 for
// completion with a bounded retry count, and latches the pass/fail results.
module memtest_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_GAP   = 16,
    parameter int MAX_POLLS  = 65535
) (
    input  logic                  axi_aclk,
    input  logic                  axi_reset,
    input  logic                  start,
    input  logic [63:0]           cfg_pattern,
    input  logic                  cfg_lfsr_en,
    input  logic [31:0]           cfg_size,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic [DATA_WIDTH-1:0] dq_fail_q,
    output logic [15:0]           poll_count,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [DATA_WIDTH-1:0] axi_wdata,
    output logic [3:0]            axi_wstrb,
    output logic                  axi_wvalid,
    output logic                  axi_wlast,
    input  logic                  axi_wready,
    input  logic                  axi_bvalid,
    output logic                  axi_bready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  axi_rvalid,
    input  logic                  axi_rlast,
    output logic                  axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_GAP, S_DONE
    } state_t;

    localparam logic [3:0] STEP_POLL = 4'd7;
    localparam logic [3:0] STEP_DQ   = 4'd8;
    localparam logic [3:0] STEP_CLR  = 4'd9;

    // Register index used by each step; byte address is index * 4.
    function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [3:0] s);
        logic [3:0] reg_idx;
        case (s)
            4'd0:       reg_idx = 4'd3;
            4'd1:       reg_idx = 4'd4;
            4'd2:       reg_idx = 4'd5;
            4'd3:       reg_idx = 4'd6;
            4'd4:       reg_idx = 4'd9;
            4'd5, 4'd6: reg_idx = 4'd2;
            4'd7:       reg_idx = 4'd1;
            4'd8:       reg_idx = 4'd0;
            4'd9:       reg_idx = 4'd2;
            default:    reg_idx = 4'd0;
        endcase
        return ADDR_WIDTH'({reg_idx, 2'b00});
    endfunction

    // Write payload for each write step; config is sampled when the step issues.
    function automatic logic [DATA_WIDTH-1:0] step_wdata(input logic [3:0]  s,
                                                         input logic [63:0] pat,
                                                         input logic        lfsr,
                                                         input logic [31:0] size);
        case (s)
            4'd0:    return DATA_WIDTH'(32'h1F);
            4'd1:    return DATA_WIDTH'(pat[31:0]);
            4'd2:    return DATA_WIDTH'(pat[63:32]);
            4'd3:    return DATA_WIDTH'(lfsr);
            4'd4:    return DATA_WIDTH'(size);
            4'd5:    return DATA_WIDTH'(32'h2);
            4'd6:    return DATA_WIDTH'(32'h3);
            4'd9:    return DATA_WIDTH'(32'h2);
            default: return '0;
        endcase
    endfunction

    function automatic logic step_is_read(input logic [3:0] s);
        return (s == STEP_POLL) || (s == STEP_DQ);
    endfunction

    state_t                state_q;
    logic [3:0]            step_q;
    logic [15:0]           gap_q;
    logic [15:0]           poll_q;
    logic                  busy_q, done_q, pass_q, fail_q, timeout_q;
    logic [DATA_WIDTH-1:0] dq_q;
    logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

    logic [15:0]           poll_d;
    logic [3:0]            step_d;

    // Saturating poll counter increment and next sequential step.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        poll_d = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
        step_d = step_q + 4'd1;
    end

    // Sequencer FSM; every AXI and status output comes straight from a flop,
    // so there is no combinational path from any ready input to a valid output.
    // NOTE: asynchronous reset sits in the sensitivity list so outputs clear without a clock.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_q   <= S_IDLE;
            step_q    <= '0;
            gap_q     <= '0;
            poll_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            dq_q      <= '0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        fail_q    <= 1'b0;
                        timeout_q <= 1'b0;
                        dq_q      <= '0;
                        poll_q    <= '0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        step_q    <= 4'd0;
                        awaddr_q  <= step_addr(4'd0);
                        wdata_q   <= step_wdata(4'd0, cfg_pattern, cfg_lfsr_en, cfg_size);
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_WR_REQ;
                    end
                end

                S_WR_REQ: begin
                    // Address and data channels handshake independently.
                    if (awvalid_q && axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && axi_wready)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end

                S_WR_RESP: begin
                    if (axi_bvalid) begin
                        bready_q <= 1'b0;
                        step_q   <= step_d;
                        if (step_q == STEP_CLR) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= !fail_q && !timeout_q;
                            state_q <= S_DONE;
                        end else if (step_is_read(step_d)) begin
                            araddr_q  <= step_addr(step_d);
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_REQ;
                        end else begin
                            awaddr_q  <= step_addr(step_d);
                            wdata_q   <= step_wdata(step_d, cfg_pattern, cfg_lfsr_en, cfg_size);
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end
                    end
                end

                S_RD_REQ: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (axi_rvalid) begin
                        rready_q <= 1'b0;
                        if (step_q == STEP_POLL) begin
                            poll_q <= poll_d;
                            if (axi_rdata[0]) begin
                                // Test finished: record verdict, then read DQ failures.
                                fail_q    <= axi_rdata[1];
                                step_q    <= STEP_DQ;
                                araddr_q  <= step_addr(STEP_DQ);
                                arvalid_q <= 1'b1;
                                state_q   <= S_RD_REQ;
                            end else if (poll_d == 16'(MAX_POLLS)) begin
                                // Out of retries: skip REG0 and go clear the start bit.
                                timeout_q <= 1'b1;
                                step_q    <= STEP_CLR;
                                awaddr_q  <= step_addr(STEP_CLR);
                                wdata_q   <= step_wdata(STEP_CLR, cfg_pattern, cfg_lfsr_en, cfg_size);
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= S_WR_REQ;
                            end else begin
                                gap_q   <= '0;
                                state_q <= S_GAP;
                            end
                        end else begin
                            dq_q      <= axi_rdata;
                            step_q    <= STEP_CLR;
                            awaddr_q  <= step_addr(STEP_CLR);
                            wdata_q   <= step_wdata(STEP_CLR, cfg_pattern, cfg_lfsr_en, cfg_size);
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_q == 16'(POLL_GAP - 1)) begin
                        araddr_q  <= step_addr(STEP_POLL);
                        arvalid_q <= 1'b1;
                        state_q   <= S_RD_REQ;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Single-beat transfers: rlast carries no information for this master.
    logic unused_rlast;
    assign unused_rlast = axi_rlast;

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign dq_fail_q   = dq_q;
    assign poll_count  = poll_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = 4'hF;
    assign axi_wvalid  = wvalid_q;
    assign axi_wlast   = wvalid_q;
    assign axi_bready  = bready_q;
    assign axi_araddr  = araddr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;

endmodule

// File: tb/tb_memtest_sequencer.sv
// Directed bench for memtest_sequencer with a behavioural AXI-Lite register slave.
module tb_memtest_sequencer;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int POLL_GAP  = 3;
    localparam int MAX_POLLS = 4;

    logic          clk = 1'b0;
    logic          axi_reset;
    logic          start;
    logic [63:0]   cfg_pattern;
    logic          cfg_lfsr_en;
    logic [31:0]   cfg_size;
    logic          busy, done, pass, fail, timeout;
    logic [DW-1:0] dq_fail_q;
    logic [15:0]   poll_count;
    logic [AW-1:0] axi_awaddr, axi_araddr;
    logic          axi_awvalid, axi_awready, axi_wvalid, axi_wlast, axi_wready;
    logic [DW-1:0] axi_wdata, axi_rdata;
    logic [3:0]    axi_wstrb;
    logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic          axi_rvalid, axi_rlast, axi_rready;

    memtest_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)
    ) dut (
        .axi_aclk(clk), .axi_reset(axi_reset), .start(start),
        .cfg_pattern(cfg_pattern), .cfg_lfsr_en(cfg_lfsr_en), .cfg_size(cfg_size),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .dq_fail_q(dq_fail_q), .poll_count(poll_count),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wlast(axi_wlast), .axi_wready(axi_wready),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast),
        .axi_rready(axi_rready)
    );

    always #5 clk = ~clk;

    // ---------------- slave model ----------------
    int          w_lat, b_lat, done_on_poll;
    logic [31:0] reg1_val, reg0_val;
    logic        clr;

    logic        got_aw, got_w, bpend;
    int          b_cnt, w_cnt, cyc, polls;
    logic [31:0] cap_addr, cap_data;
    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    logic [31:0] rd_addr [32];
    int          rd_cyc  [32];
    int          wr_n, rd_n, aw_hs_n, w_hs_n, aw_hi, w_hi;
    logic        aw_hs, w_hs;

    assign axi_awready = 1'b1;
    assign axi_arready = 1'b1;
    assign axi_wready  = (w_cnt >= w_lat);
    assign axi_rlast   = axi_rvalid;
    assign aw_hs       = axi_awvalid && axi_awready;
    assign w_hs        = axi_wvalid && axi_wready;

    always @(posedge clk or posedge axi_reset) begin
        if (axi_reset || clr) begin
            got_aw <= 0; got_w <= 0; bpend <= 0; b_cnt <= 0; w_cnt <= 0;
            axi_bvalid <= 0; axi_rvalid <= 0; axi_rdata <= '0;
            wr_n <= 0; rd_n <= 0; polls <= 0; aw_hs_n <= 0; w_hs_n <= 0;
            aw_hi <= 0; w_hi <= 0; cyc <= 0; cap_addr <= '0; cap_data <= '0;
        end else begin
            cyc <= cyc + 1;
            if (axi_awvalid) aw_hi <= aw_hi + 1;
            if (axi_wvalid)  w_hi  <= w_hi + 1;
            if (aw_hs) begin
                got_aw <= 1; cap_addr <= axi_awaddr; aw_hs_n <= aw_hs_n + 1;
            end
            if (w_hs) begin
                got_w <= 1; cap_data <= axi_wdata; w_hs_n <= w_hs_n + 1; w_cnt <= 0;
            end else if (axi_wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                got_aw <= 0; got_w <= 0;
                if (b_lat <= 1) axi_bvalid <= 1;
                else begin bpend <= 1; b_cnt <= 1; end
            end
            if (bpend) begin
                b_cnt <= b_cnt + 1;
                if (b_cnt + 1 >= b_lat) begin axi_bvalid <= 1; bpend <= 0; end
            end
            if (axi_bvalid && axi_bready) begin
                axi_bvalid <= 0;
                if (wr_n < 32) begin wr_addr[wr_n] <= cap_addr; wr_data[wr_n] <= cap_data; end
                wr_n <= wr_n + 1;
            end
            if (axi_arvalid && axi_arready) begin
                axi_rvalid <= 1;
                if (rd_n < 32) begin rd_addr[rd_n] <= axi_araddr; rd_cyc[rd_n] <= cyc; end
                rd_n <= rd_n + 1;
                if (axi_araddr == 32'd4) begin
                    polls <= polls + 1;
                    axi_rdata <= (done_on_poll != 0 && polls + 1 == done_on_poll) ? reg1_val : 32'h0;
                end else if (axi_araddr == 32'd0) begin
                    axi_rdata <= reg0_val;
                end else begin
                    axi_rdata <= 32'h0;
                end
            end else if (axi_rvalid && axi_rready) begin
                axi_rvalid <= 0;
            end
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        @(negedge clk) clr = 1;
        @(negedge clk) clr = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1);
    endtask

    typedef struct {
        int          done_on;
        logic [31:0] reg1;
        logic [31:0] reg0;
        logic [63:0] pat;
        logic        lfsr;
        logic [31:0] size;
        logic        exp_pass;
        logic        exp_fail;
        logic        exp_to;
        int          exp_pc;
        logic [31:0] exp_dq;
        int          exp_reads;
    } vec_t;

    vec_t vecs [5];

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] exp_wa [8];
        logic [31:0] exp_wd [8];
        exp_wa = '{32'd12, 32'd16, 32'd20, 32'd24, 32'd36, 32'd8, 32'd8, 32'd8};
        exp_wd = '{32'h1F, v.pat[31:0], v.pat[63:32], {31'b0, v.lfsr}, v.size,
                   32'h2, 32'h3, 32'h2};
        done_on_poll = v.done_on; reg1_val = v.reg1; reg0_val = v.reg0;
        cfg_pattern = v.pat; cfg_lfsr_en = v.lfsr; cfg_size = v.size;
        w_lat = 0; b_lat = 1;
        clear_logs();
        pulse_start();
        check($sformatf("v%0d_busy_after_start", idx), busy, 1);
        check($sformatf("v%0d_done_cleared", idx), done, 0);
        wait_done(500);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_done_held", idx), {busy, done}, 2'b01);
        check($sformatf("v%0d_pass", idx), pass, v.exp_pass);
        check($sformatf("v%0d_fail", idx), fail, v.exp_fail);
        check($sformatf("v%0d_timeout", idx), timeout, v.exp_to);
        check($sformatf("v%0d_poll_count", idx), poll_count, 64'(v.exp_pc));
        check($sformatf("v%0d_dq_fail", idx), dq_fail_q, v.exp_dq);
        check($sformatf("v%0d_writes", idx), 64'(wr_n), 64'd8);
        check($sformatf("v%0d_reads", idx), 64'(rd_n), 64'(v.exp_reads));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("v%0d_wr%0d_addr", idx, i), wr_addr[i], exp_wa[i]);
            check($sformatf("v%0d_wr%0d_data", idx, i), wr_data[i], exp_wd[i]);
        end
        for (int i = 0; i < v.exp_pc; i++)
            check($sformatf("v%0d_rd%0d_reg1", idx, i), rd_addr[i], 32'd4);
        for (int i = 1; i < v.exp_pc; i++)
            check($sformatf("v%0d_poll_gap%0d", idx, i), 64'(rd_cyc[i] - rd_cyc[i-1]),
                  64'(POLL_GAP + 2));
        if (!v.exp_to)
            check($sformatf("v%0d_rd_reg0", idx), rd_addr[v.exp_pc], 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3, 32'h1, 32'hDEADBEEF, 64'h01234567_89ABCDEF, 1'b1, 32'h0010_0000,
                    1'b1, 1'b0, 1'b0, 3, 32'hDEADBEEF, 4};
        vecs[1] = '{1, 32'h3, 32'h0000_00F0, 64'hFFFF0000_A5A5A5A5, 1'b0, 32'h0000_0400,
                    1'b0, 1'b1, 1'b0, 1, 32'h0000_00F0, 2};
        vecs[2] = '{0, 32'h0, 32'h1234_5678, 64'h11111111_22222222, 1'b1, 32'h0000_0008,
                    1'b0, 1'b0, 1'b1, 4, 32'h0, 4};
        vecs[3] = '{4, 32'h1, 32'hCAFE_0001, 64'h80000000_00000001, 1'b0, 32'h0000_0001,
                    1'b1, 1'b0, 1'b0, 4, 32'hCAFE_0001, 5};
        vecs[4] = '{2, 32'h5, 32'h0, 64'h0F0F0F0F_F0F0F0F0, 1'b0, 32'hFFFF_FFFF,
                    1'b1, 1'b0, 1'b0, 2, 32'h0, 3};

        axi_reset = 1; start = 0; clr = 0;
        cfg_pattern = '0; cfg_lfsr_en = 0; cfg_size = '0;
        w_lat = 0; b_lat = 1; done_on_poll = 0; reg1_val = 0; reg0_val = 0;
        repeat (3) @(negedge clk);
        check("reset_status", {busy, done, pass, fail, timeout}, 5'b0);
        check("reset_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 5'b0);
        check("reset_results", {dq_fail_q, poll_count}, 48'h0);
        axi_reset = 0;
        @(negedge clk);
        check("idle_no_busy", busy, 0);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Slow slave: wready 3 cycles late, bvalid 5 cycles late; a start pulse mid-run is ignored.
        done_on_poll = 1; reg1_val = 32'h1; reg0_val = 32'h0000_0042;
        cfg_pattern = 64'hAAAAAAAA_55555555; cfg_lfsr_en = 1; cfg_size = 32'h100;
        w_lat = 3; b_lat = 5;
        clear_logs();
        pulse_start();
        repeat (10) @(negedge clk);
        check("slow_busy_mid", busy, 1);
        pulse_start();
        wait_done(800);
        check("slow_aw_handshakes", 64'(aw_hs_n), 64'd8);
        check("slow_w_handshakes", 64'(w_hs_n), 64'd8);
        check("slow_awvalid_cycles", 64'(aw_hi), 64'd8);
        check("slow_wvalid_cycles", 64'(w_hi), 64'd32);
        check("slow_writes", 64'(wr_n), 64'd8);
        check("slow_first_write", {wr_addr[0], wr_data[0]}, {32'd12, 32'h1F});
        check("slow_last_write", {wr_addr[7], wr_data[7]}, {32'd8, 32'h2});
        check("slow_results", {pass, fail, timeout, poll_count, dq_fail_q},
              {3'b100, 16'd1, 32'h0000_0042});

        // Reset during step 3 write response, then a clean rerun.
        w_lat = 0; b_lat = 5;
        clear_logs();
        pulse_start();
        begin
            int n = 0;
            while (!(aw_hs_n == 4 && axi_bready === 1'b1) && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("rst_reached_step3", {64'(aw_hs_n), 63'b0, axi_bready}, {64'd4, 64'd1});
        end
        check("rst_pre_addr", axi_awaddr, 32'd24);
        axi_reset = 1;
        #1;
        check("rst_status", {busy, done, pass, fail, timeout}, 5'b0);
        check("rst_valids", {axi_awvalid, axi_wvalid, axi_arvalid, axi_bready, axi_rready}, 5'b0);
        check("rst_addr_data", {axi_awaddr, axi_araddr, axi_wdata}, 96'h0);
        check("rst_results", {dq_fail_q, poll_count}, 48'h0);
        @(negedge clk) axi_reset = 0;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", {busy, axi_awvalid}, 2'b00);
        b_lat = 1;
        pulse_start();
        wait_done(500);
        check("rerun_writes", 64'(wr_n), 64'd8);
        check("rerun_first_write", {wr_addr[0], wr_data[0]}, {32'd12, 32'h1F});
        check("rerun_lfsr_write", {wr_addr[3], wr_data[3]}, {32'd24, 32'h1});
        check("rerun_pass", {pass, poll_count, dq_fail_q}, {1'b1, 16'd1, 32'h0000_0042});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
